// File: rtl/rx_frame_pkg.sv
// Shared definitions for the UART-to-CORDIC frame sequencer: state encoding,
// default sync marker and payload byte-count helper.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_START   = 3'd4,
    ST_WAIT    = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

  function automatic int calc_nb(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: clears on every received byte, counts only while enabled,
// and raises tc while the count sits at TIMEOUT_CYC-1.
module rx_gap_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || !en)
      cnt <= '0;
    else if (cnt != TERM)
      cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == TERM);

endmodule

// File: rtl/rx_frame_sequencer.sv
// Frame parser between the UART receiver and the CORDIC core: [SYNC][CMD][payload][chk].
// Build option RX_CHECKSUM_EN adds the trailing XOR checksum byte and err_chk.
module rx_frame_sequencer
  import rx_frame_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] op_data,
  output logic [7:0]        op_cmd,
  output logic              op_start,
  input  logic              op_done,
  output logic              busy,
  output logic              err_chk,
  output logic              err_tmo,
  output logic              err_ovr
);

  localparam int NB = calc_nb(DATA_W);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] data_n;
  logic [7:0]        cmd_n;
  logic [IW-1:0]     idx, idx_n;
  logic              busy_n, start_n, tmo_n, ovr_n;
  logic              gap_en, gap_tc;
`ifdef RX_CHECKSUM_EN
  logic [7:0]        acc, acc_n;
  logic              chk_n;
`endif

  assign gap_en = (state == ST_CMD) || (state == ST_PAYLOAD) || (state == ST_CHECK);

  rx_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk (clk),
    .rst (rst),
    .clr (rx_done),
    .en  (gap_en),
    .tc  (gap_tc)
  );

  always_comb begin
    state_n = state;
    data_n  = op_data;
    cmd_n   = op_cmd;
    idx_n   = idx;
    busy_n  = busy;
    start_n = 1'b0;
    tmo_n   = 1'b0;
    ovr_n   = 1'b0;
`ifdef RX_CHECKSUM_EN
    acc_n   = acc;
    chk_n   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (rx_done && rx_data == SYNC_BYTE) begin
          state_n = ST_CMD;
          busy_n  = 1'b1;
`ifdef RX_CHECKSUM_EN
          acc_n   = 8'h00;
`endif
        end
      end
      ST_CMD: begin
        if (rx_done) begin
          cmd_n   = rx_data;
          idx_n   = '0;
          state_n = ST_PAYLOAD;
`ifdef RX_CHECKSUM_EN
          acc_n   = acc ^ rx_data;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (rx_done) begin
          data_n = (op_data << 8) | DATA_W'(rx_data);
          idx_n  = idx + 1'b1;
`ifdef RX_CHECKSUM_EN
          acc_n  = acc ^ rx_data;
          if (idx == LAST_IDX) state_n = ST_CHECK;
`else
          if (idx == LAST_IDX) begin
            state_n = ST_START;
            start_n = 1'b1;
          end
`endif
        end
      end
`ifdef RX_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_done) begin
          if (rx_data == acc) begin
            state_n = ST_START;
            start_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            chk_n   = 1'b1;
          end
        end
      end
`endif
      ST_START: begin
        state_n = ST_WAIT;
        ovr_n   = rx_done;
      end
      ST_WAIT: begin
        ovr_n = rx_done;
        if (op_done) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A byte in the terminal cycle has already been taken above and wins.
    if (gap_tc && !rx_done) begin
      state_n = ST_IDLE;
      busy_n  = 1'b0;
      tmo_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_data  <= '0;
      op_cmd   <= 8'h00;
      idx      <= '0;
      busy     <= 1'b0;
      op_start <= 1'b0;
      err_tmo  <= 1'b0;
      err_ovr  <= 1'b0;
    end else begin
      state    <= state_n;
      op_data  <= data_n;
      op_cmd   <= cmd_n;
      idx      <= idx_n;
      busy     <= busy_n;
      op_start <= start_n;
      err_tmo  <= tmo_n;
      err_ovr  <= ovr_n;
    end
  end

`ifdef RX_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= 8'h00;
      err_chk <= 1'b0;
    end else begin
      acc     <= acc_n;
      err_chk <= chk_n;
    end
  end
`else
  assign err_chk = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench for rx_frame_sequencer (DATA_W=32, TIMEOUT_CYC=100); checksum
// bytes are sent only when RX_CHECKSUM_EN is defined.
module tb_rx_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [31:0] op_data;
  logic [7:0]  op_cmd;
  logic        op_start;
  logic        op_done = 1'b0;
  logic        busy;
  logic        err_chk;
  logic        err_tmo;
  logic        err_ovr;

  int checks   = 0;
  int failures = 0;

  rx_frame_sequencer #(
    .DATA_W      (32),
    .TIMEOUT_CYC (100),
    .SYNC_BYTE   (8'hAA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .op_data  (op_data),
    .op_cmd   (op_cmd),
    .op_start (op_start),
    .op_done  (op_done),
    .busy     (busy),
    .err_chk  (err_chk),
    .err_tmo  (err_tmo),
    .err_ovr  (err_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte presented for one cycle, followed by one idle cycle; returns on a negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d, input logic [7:0] chk);
    send_byte(8'hAA);
    send_byte(cmd);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
`ifdef RX_CHECKSUM_EN
    send_byte(d[7:0]);
    send_byte(chk);
`else
    if (chk == 8'h00) ;
    send_byte(d[7:0]);
`endif
  endtask

  task automatic finish_op(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  int tmo_pulses;
  int tmo_first;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_op_data", op_data, 32'h0);
    check("rst_op_cmd", {24'd0, op_cmd}, 32'h0);
    check("rst_flags", {26'd0, op_start, busy, err_chk, err_tmo, err_ovr, 1'b0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame
    send_frame(8'h05, 32'h3F800000, 8'hBA);
    check("f1_start", {31'd0, op_start}, 32'd1);
    check("f1_cmd", {24'd0, op_cmd}, 32'h05);
    check("f1_data", op_data, 32'h3F800000);
    check("f1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("f1_start_one", {31'd0, op_start}, 32'd0);
    finish_op("f1");
    check("f1_err_chk", {31'd0, err_chk}, 32'd0);

`ifdef RX_CHECKSUM_EN
    // Bad checksum
    send_frame(8'h05, 32'h3F800000, 8'hBB);
    check("f2_err_chk", {31'd0, err_chk}, 32'd1);
    check("f2_no_start", {31'd0, op_start}, 32'd0);
    check("f2_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("f2_chk_one", {31'd0, err_chk}, 32'd0);
`endif

    // Inter-byte timeout
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3F);
    tmo_pulses = 0;
    tmo_first  = -1;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      if (err_tmo) begin
        tmo_pulses++;
        if (tmo_first < 0) tmo_first = i;
      end
    end
    check("tmo_pulses", tmo_pulses, 32'd1);
    check("tmo_cycle", tmo_first, 32'd100);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h09, 32'h12345678, 8'h09 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    check("tmo_next_start", {31'd0, op_start}, 32'd1);
    check("tmo_next_data", op_data, 32'h12345678);
    finish_op("tmo_next");

    // Sync value inside payload is data
    send_frame(8'h07, 32'hAA000001, 8'hAC);
    check("aa_data", op_data, 32'hAA000001);
    check("aa_start", {31'd0, op_start}, 32'd1);

    // Overrun while waiting on the core
    send_byte(8'h55);
    check("ovr_flag", {31'd0, err_ovr}, 32'd1);
    check("ovr_data", op_data, 32'hAA000001);
    @(negedge clk);
    check("ovr_one", {31'd0, err_ovr}, 32'd0);
    finish_op("ovr");

    // Garbage in idle
    send_byte(8'h12);
    check("garb1", {28'd0, busy, err_chk, err_tmo, err_ovr}, 32'd0);
    send_byte(8'h34);
    check("garb2", {28'd0, busy, err_chk, err_tmo, err_ovr}, 32'd0);

    // Async reset mid-payload
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_data", op_data, 32'h0);
    check("arst_cmd", {24'd0, op_cmd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h01, 32'h00000002, 8'h03);
    check("post_rst_start", {31'd0, op_start}, 32'd1);
    check("post_rst_data", op_data, 32'h00000002);
    check("post_rst_cmd", {24'd0, op_cmd}, 32'h01);
    finish_op("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
